// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard, forwarding and delay-slot annul controller
// Shadows EX/MEM/WB destination info; stall/flush outputs gate PC, NPC and IF/ID.
module pipe_hazard_ctrl #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic                id_rd_used,
  input  logic                id_rf_le,
  input  logic                id_load,
  input  logic                id_psr_en,
  input  logic                id_branch,
  input  logic                id_annul,
  input  logic                id_taken,
  output logic                pc_le,
  output logic                ifid_le,
  output logic                ifid_clr,
  output logic                ex_bubble,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [1:0]          fwd_d,
  output logic [CNT_BITS-1:0] stall_cnt,
  output logic [CNT_BITS-1:0] annul_cnt
);

  typedef struct packed {
    logic                v;
    logic [REG_BITS-1:0] rd;
    logic                rf_le;
    logic                load;
    logic                psr;
  } ex_slot_t;

  // Past EX only forwarding looks at a slot, so load/psr are not carried further.
  typedef struct packed {
    logic                v;
    logic [REG_BITS-1:0] rd;
    logic                rf_le;
  } wb_slot_t;

  ex_slot_t            r_ex;
  wb_slot_t            r_mem;
  wb_slot_t            r_wb;
  logic [CNT_BITS-1:0] r_stall_cnt;
  logic [CNT_BITS-1:0] r_annul_cnt;

  logic w_load_use;
  logic w_cc_haz;
  logic w_stall;
  logic w_issue;
  logic w_clr;

  function automatic logic wr_hit(input logic v, input logic rf_le,
                                  input logic [REG_BITS-1:0] rd,
                                  input logic [REG_BITS-1:0] r);
    return v & rf_le & (rd == r) & (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_BITS-1:0] r,
                                         input ex_slot_t ex, input wb_slot_t mem,
                                         input wb_slot_t wb);
    if (!used)                                         return 2'b00;
    if (wr_hit(ex.v, ex.rf_le, ex.rd, r) && !ex.load)  return 2'b01;
    if (wr_hit(mem.v, mem.rf_le, mem.rd, r))           return 2'b10;
    if (wr_hit(wb.v, wb.rf_le, wb.rd, r))              return 2'b11;
    return 2'b00;
  endfunction

  assign w_load_use = r_ex.load &
                      ((id_rs1_used & wr_hit(r_ex.v, r_ex.rf_le, r_ex.rd, id_rs1)) |
                       (id_rs2_used & wr_hit(r_ex.v, r_ex.rf_le, r_ex.rd, id_rs2)) |
                       (id_rd_used  & wr_hit(r_ex.v, r_ex.rf_le, r_ex.rd, id_rd)));
  assign w_cc_haz   = id_valid & id_branch & r_ex.v & r_ex.psr;
  assign w_stall    = rst_n & (w_load_use | w_cc_haz);
  assign w_issue    = id_valid & ~w_stall;
  // Annul only on a real advance, and never while reset holds the pipe.
  assign w_clr      = rst_n & id_valid & id_branch & id_annul & ~id_taken & ~w_stall;

  assign pc_le     = ~w_stall;
  assign ifid_le   = ~w_stall;
  assign ifid_clr  = w_clr;
  assign ex_bubble = w_stall | ~id_valid;
  assign fwd_a     = fwd_sel(id_rs1_used, id_rs1, r_ex, r_mem, r_wb);
  assign fwd_b     = fwd_sel(id_rs2_used, id_rs2, r_ex, r_mem, r_wb);
  assign fwd_d     = fwd_sel(id_rd_used,  id_rd,  r_ex, r_mem, r_wb);
  assign stall_cnt = r_stall_cnt;
  assign annul_cnt = r_annul_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb        <= r_mem;
      r_mem.v     <= r_ex.v;
      r_mem.rd    <= r_ex.rd;
      r_mem.rf_le <= r_ex.rf_le;
      r_ex        <= w_issue ? {1'b1, id_rd, id_rf_le, id_load, id_psr_en} : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_annul_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
      if (w_clr && (r_annul_cnt != '1))   r_annul_cnt <= r_annul_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
// Stimulus pushes expected outputs; the negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int RB = 5;
  localparam int CB = 4;

  localparam logic [3:0] RUN = 4'b1100;  // {pc_le, ifid_le, ifid_clr, ex_bubble}
  localparam logic [3:0] BUB = 4'b1101;
  localparam logic [3:0] STL = 4'b0001;
  localparam logic [3:0] CLR = 4'b1110;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_rs1_used, id_rs2_used, id_rd_used;
  logic [RB-1:0] id_rs1, id_rs2, id_rd;
  logic          id_rf_le, id_load, id_psr_en, id_branch, id_annul, id_taken;
  logic          pc_le, ifid_le, ifid_clr, ex_bubble;
  logic [1:0]    fwd_a, fwd_b, fwd_d;
  logic [CB-1:0] stall_cnt, annul_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_used(id_rd_used),
    .id_rf_le(id_rf_le), .id_load(id_load), .id_psr_en(id_psr_en),
    .id_branch(id_branch), .id_annul(id_annul), .id_taken(id_taken),
    .pc_le(pc_le), .ifid_le(ifid_le), .ifid_clr(ifid_clr), .ex_bubble(ex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_d(fwd_d),
    .stall_cnt(stall_cnt), .annul_cnt(annul_cnt)
  );

  typedef struct {
    string       name;
    logic [17:0] exp;
  } chk_t;

  chk_t        q[$];
  chk_t        m_c;
  logic [17:0] m_act;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [3:0]  exp_sc;

  function automatic string fmt(input logic [17:0] x);
    return $sformatf("ctl=%b fa=%b fb=%b fd=%b sc=%0d ac=%0d",
                     x[17:14], x[13:12], x[11:10], x[9:8], x[7:4], x[3:0]);
  endfunction

  function automatic logic [17:0] e(input logic [3:0] ctl, input logic [1:0] fa,
                                    input logic [1:0] fb, input logic [1:0] fd,
                                    input logic [3:0] sc, input logic [3:0] ac);
    return {ctl, fa, fb, fd, sc, ac};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_c   = q.pop_front();
      m_act = {pc_le, ifid_le, ifid_clr, ex_bubble, fwd_a, fwd_b, fwd_d, stall_cnt, annul_cnt};
      n_assert++;
      if (m_act !== m_c.exp) begin
        n_fail++;
        $display("FAIL %s: actual %s, required %s", m_c.name, fmt(m_act), fmt(m_c.exp));
      end
    end
  end

  task automatic id_set(input logic v, input logic [RB-1:0] rs1, input logic [RB-1:0] rs2,
                        input logic [RB-1:0] rd, input logic u1, input logic u2,
                        input logic ud, input logic rf, input logic ld, input logic psr,
                        input logic br, input logic an, input logic tk);
    id_valid = v;  id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;
    id_rs1_used = u1;  id_rs2_used = u2;  id_rd_used = ud;
    id_rf_le = rf;  id_load = ld;  id_psr_en = psr;
    id_branch = br;  id_annul = an;  id_taken = tk;
  endtask

  task automatic nop();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic alu(input logic [RB-1:0] rd, input logic [RB-1:0] rs1,
                     input logic [RB-1:0] rs2, input logic psr);
    id_set(1, rs1, rs2, rd, 1, 1, 0, 1, 0, psr, 0, 0, 0);
  endtask
  task automatic load(input logic [RB-1:0] rd, input logic [RB-1:0] rs1);
    id_set(1, rs1, 0, rd, 1, 0, 0, 1, 1, 0, 0, 0, 0);
  endtask
  task automatic store(input logic [RB-1:0] rd, input logic [RB-1:0] rs1);
    id_set(1, rs1, 0, rd, 1, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic branch(input logic an, input logic tk);
    id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, an, tk);
  endtask

  task automatic cyc(input string name, input logic [17:0] exp);
    q.push_back('{name, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    nop();
    @(posedge clk);
    #1;
    cyc("rst_nop",     e(BUB, 0, 0, 0, 0, 0));
    branch(1, 0);
    cyc("rst_no_clr",  e(RUN, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    nop();
    cyc("empty_pipe",  e(BUB, 0, 0, 0, 0, 0));

    load(5, 1);        cyc("t1_load",      e(RUN, 2'b00, 0, 0, 0, 0));
    alu(6, 5, 2, 0);   cyc("t1_stall",     e(STL, 2'b00, 0, 0, 0, 0));
    alu(6, 5, 2, 0);   cyc("t1_fwd_mem",   e(RUN, 2'b10, 0, 0, 1, 0));

    alu(3, 0, 0, 0);   cyc("t2_add3_a",    e(RUN, 0, 0, 0, 1, 0));
    alu(3, 0, 0, 0);   cyc("t2_add3_b",    e(RUN, 0, 0, 0, 1, 0));
    alu(3, 0, 0, 0);   cyc("t2_add3_c",    e(RUN, 0, 0, 0, 1, 0));
    alu(9, 0, 3, 0);   cyc("t2_fwd_ex",    e(RUN, 0, 2'b01, 0, 1, 0));
    alu(10, 0, 3, 0);  cyc("t2_fwd_mem",   e(RUN, 0, 2'b10, 0, 1, 0));
    alu(11, 0, 3, 0);  cyc("t2_fwd_wb",    e(RUN, 0, 2'b11, 0, 1, 0));

    alu(0, 0, 0, 0);   cyc("t3_wr_r0",     e(RUN, 0, 0, 0, 1, 0));
    alu(12, 0, 0, 0);  cyc("t3_rd_r0",     e(RUN, 0, 0, 0, 1, 0));
    load(0, 12);       cyc("t3_ld_r0",     e(RUN, 2'b01, 0, 0, 1, 0));
    alu(13, 0, 0, 0);  cyc("t3_ld_r0_use", e(RUN, 0, 0, 0, 1, 0));

    alu(14, 0, 0, 1);  cyc("t4_subcc",     e(RUN, 0, 0, 0, 1, 0));
    branch(1, 0);      cyc("t4_cc_stall",  e(STL, 0, 0, 0, 1, 0));
    branch(1, 0);      cyc("t4_annul",     e(CLR, 0, 0, 0, 2, 0));
    nop();             cyc("t4_slot_nop",  e(BUB, 0, 0, 0, 2, 1));
    alu(14, 0, 0, 1);  cyc("t4_subcc2",    e(RUN, 0, 0, 0, 2, 1));
    branch(1, 1);      cyc("t4_cc_stall2", e(STL, 0, 0, 0, 2, 1));
    branch(1, 1);      cyc("t4_taken",     e(RUN, 0, 0, 0, 3, 1));

    load(7, 0);        cyc("t5_load7",     e(RUN, 0, 0, 0, 3, 1));
    store(7, 0);       cyc("t5_st_stall",  e(STL, 0, 0, 2'b00, 3, 1));
    store(7, 0);       cyc("t5_fwd_d",     e(RUN, 0, 0, 2'b10, 4, 1));

    exp_sc = 4'd4;
    for (int i = 0; i < 13; i++) begin
      load(5, 5);
      cyc($sformatf("t6_issue_%0d", i), e(RUN, (i == 0) ? 2'b00 : 2'b10, 0, 0, exp_sc, 1));
      cyc($sformatf("t6_stall_%0d", i), e(STL, (i == 0) ? 2'b00 : 2'b11, 0, 0, exp_sc, 1));
      if (exp_sc != 4'hF) exp_sc = exp_sc + 4'd1;
    end
    cyc("t6_issue_last", e(RUN, 2'b10, 0, 0, 4'hF, 1));
    rst_n = 1'b0;
    cyc("t6_rst_mid",    e(RUN, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    cyc("t6_post_rst",   e(RUN, 0, 0, 0, 0, 0));
    nop();
    cyc("t6_no_stall",   e(BUB, 0, 0, 0, 0, 0));

    repeat (2) @(negedge clk);
    n_assert++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks left in queue, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Sequences the 5-stage integer pipeline: IF, ID, EX, MEM, WB.
- Keeps its own shadow copy of the destination info in flight for the EX, MEM and WB stages.
- Detects load-use and condition-code hazards, inserts bubbles, and drives operand-forwarding selects.
- Applies SPARC-style delay-slot annulment for conditional branches.
- Sits beside the ID-stage decoder; its stall/flush outputs gate the PC, NPC and IF/ID registers.

Parameters:
REG_BITS, 5, register specifier width
CNT_BITS, 16, stall/annul counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction (0 = bubble)
id_rs1  in  REG_BITS  source 1 specifier
id_rs2  in  REG_BITS  source 2 specifier
id_rd  in  REG_BITS  destination (store-data source for stores)
id_rs1_used  in  1  rs1 is read
id_rs2_used  in  1  rs2 is read (register-form operand)
id_rd_used  in  1  rd is read as store data
id_rf_le  in  1  instruction writes register file
id_load  in  1  instruction is a load
id_psr_en  in  1  instruction writes condition codes
id_branch  in  1  conditional branch in ID
id_annul  in  1  annul bit of the branch
id_taken  in  1  branch condition true (valid when id_branch)
pc_le  out  1  PC/NPC load enable
ifid_le  out  1  IF/ID load enable
ifid_clr  out  1  replace IF/ID contents with nop next edge
ex_bubble  out  1  insert nop into ID/EX
fwd_a  out  2  rs1 forwarding select
fwd_b  out  2  rs2 forwarding select
fwd_d  out  2  store-data forwarding select
stall_cnt  out  CNT_BITS  saturating count of stall cycles
annul_cnt  out  CNT_BITS  saturating count of annulled slots

Behaviour:
- Shadow slots EX, MEM, WB, each holding {v, rd, rf_le, load, psr}.
- Each edge: WB<=MEM, MEM<=EX. EX <= ID info if issue, else an invalid slot.
- issue = id_valid & ~stall.
- A slot "writes r" when v & rf_le & rd==r & r!=0. Register 0 never hazards or forwards.
- load_use = EX slot is a load and writes any ID source actually used (rs1_used/rs2_used/rd_used).
- cc_haz = id_valid & id_branch & EX.v & EX.psr.
- stall = load_use | cc_haz.
- During stall: pc_le=0, ifid_le=0, ex_bubble=1.
- Otherwise: pc_le=1, ifid_le=1, ex_bubble=~id_valid.
- A simultaneous load_use and cc_haz gives one stall cycle, re-evaluated the next cycle.
- Forward select for a used source, first match wins:
  - EX writes it (non-load) -> 01.
  - else MEM writes it -> 10.
  - else WB writes it -> 11.
  - else 00.
  - Unused source -> 00.
- While stalled, fwd_* are don't-care but must still follow the rule above (no X).
- Annul: ifid_clr=1 when id_valid & id_branch & id_annul & ~id_taken & ~stall.
  - IF/ID is cleared on that edge, so the delay slot becomes a nop.
  - A taken branch never annuls.
  - ifid_clr takes effect only with ifid_le=1. Never assert ifid_clr during a stall.
- Counters:
  - stall_cnt increments on each stall cycle.
  - annul_cnt increments on each ifid_clr cycle.
  - Both saturate at all-ones and never wrap.
- Outputs are combinational from the slots and ID inputs. Slots and counters are registers.
- Reset (any time, asynchronous):
  - All slots invalid; counters = 0.
  - While rst_n=0: pc_le=1, ifid_le=1, ifid_clr=0, ex_bubble=~id_valid, fwd_*=00.
  - An in-flight hazard is discarded. The first post-reset cycle sees an empty pipeline.

Test Plan:
1. Load r5 in EX, ID add reading rs1=5 -> exactly one cycle of pc_le=0, ifid_le=0, ex_bubble=1. Next cycle fwd_a=10 (MEM), stall_cnt=1.
2. Add writing r3 in EX, MEM and WB (three back-to-back adds), ID reads rs2=3 -> fwd_b=01. With only MEM writing r3 -> 10. With only WB -> 11.
3. EX writes r0, ID reads r0 -> fwd_a=00, no stall.
4. subcc in EX, bne in ID -> one stall cycle. Then with id_annul=1, id_taken=0 -> ifid_clr=1 for one cycle, annul_cnt=1. Repeat with id_taken=1 -> ifid_clr=0.
5. Store with id_rd_used=1, rd=7, load r7 in EX -> stall. Then fwd_d=10.
6. Force stall_cnt to all-ones by continuous load-use -> holds all-ones. Assert rst_n=0 mid-stall -> counters 0, pc_le=1 immediately, no stall after release.
